// File: rtl/zilla_pkg.sv
// Shared Zilla core constants used by the fetch path.
package zilla_pkg;

   localparam int PC_WIDTH          = 20;
   localparam int INSTRUCTION_WIDTH = 32;
   localparam int FETCH_BUF_DEPTH   = 4;

   localparam logic [PC_WIDTH-1:0] BOOT_ADDR = 20'h8100;

   typedef struct packed {
      logic [INSTRUCTION_WIDTH-1:0] instr;
      logic [PC_WIDTH-1:0]          pc;
   } fetch_entry_t;

endpackage

// File: rtl/zilla_fetch_fifo.sv
// Generic synchronous FIFO with flush, occupancy count and full/empty flags.
module zilla_fetch_fifo #(
   parameter int WIDTH = 52,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   input  logic             i_flush,
   output logic [WIDTH-1:0] o_rd_data,
   output logic [AW:0]      o_count,
   output logic             o_full,
   output logic             o_empty
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_pop;

   assign w_pop = i_pop & ~o_empty;

   // Storage is cleared on reset so the head reads as zero before the first push.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({i_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_rd_data = r_mem[r_rd_ptr];
   assign o_count   = r_count;
   assign o_full    = (r_count == (AW+1)'(DEPTH));
   assign o_empty   = (r_count == '0);

endmodule

// File: rtl/zilla_fetch_buffer.sv
// Fetch buffer: issues imem reads, captures fixed-latency responses and queues
// them with their PCs for decode; stalls PC-update when the queue would overflow.
module zilla_fetch_buffer
   import zilla_pkg::*;
#(
   parameter int PC_WIDTH          = zilla_pkg::PC_WIDTH,
   parameter int INSTRUCTION_WIDTH = zilla_pkg::INSTRUCTION_WIDTH,
   parameter int DEPTH             = zilla_pkg::FETCH_BUF_DEPTH
) (
   input  logic                         z_clk,
   input  logic                         z_rst,
   input  logic [PC_WIDTH-1:0]          instr_read_addr_i,
   input  logic                         instr_read_enable_i,
   input  logic                         flush_i,
   output logic [PC_WIDTH-1:0]          imem_addr_o,
   output logic                         imem_req_o,
   input  logic [INSTRUCTION_WIDTH-1:0] imem_rdata_i,
   output logic                         instr_valid_o,
   output logic [INSTRUCTION_WIDTH-1:0] instr_o,
   output logic [PC_WIDTH-1:0]          instr_pc_o,
   input  logic                         instr_ready_i,
   output logic                         stall_valid_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = INSTRUCTION_WIDTH + PC_WIDTH;

   logic                r_inflight;
   logic [PC_WIDTH-1:0] r_inflight_pc;

   logic [AW:0]         w_count;
   logic                w_full;
   logic                w_empty;
   logic [EW-1:0]       w_head;
   logic [AW+1:0]       w_occupancy;
   logic                w_stall;
   logic                w_req;
   logic                w_push;
   logic                w_pop;

   // Occupancy includes the in-flight fetch so its slot is reserved before data returns.
   assign w_occupancy = {1'b0, w_count} + {{(AW+1){1'b0}}, r_inflight};
   assign w_stall     = (w_occupancy >= (AW+2)'(DEPTH));

   assign w_req  = instr_read_enable_i & ~w_stall & ~flush_i;
   assign w_push = r_inflight & ~flush_i;
   assign w_pop  = ~w_empty & instr_ready_i & ~flush_i;

   always_ff @(posedge z_clk or negedge z_rst) begin
      if (!z_rst) begin
         r_inflight    <= 1'b0;
         r_inflight_pc <= '0;
      end else begin
         r_inflight <= w_req;
         if (w_req) begin
            r_inflight_pc <= instr_read_addr_i;
         end
      end
   end

   zilla_fetch_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk       (z_clk),
      .i_rst_n     (z_rst),
      .i_push      (w_push),
      .i_push_data ({imem_rdata_i, r_inflight_pc}),
      .i_pop       (w_pop),
      .i_flush     (flush_i),
      .o_rd_data   (w_head),
      .o_count     (w_count),
      .o_full      (w_full),
      .o_empty     (w_empty)
   );

   a_no_overflow: assert property (@(posedge z_clk) disable iff (!z_rst) !(w_push && w_full));

   assign imem_addr_o   = instr_read_addr_i;
   assign imem_req_o    = w_req;
   assign stall_valid_o = w_stall;
   assign instr_valid_o = ~w_empty;
   assign {instr_o, instr_pc_o} = w_head;

endmodule

// File: doc/zilla_fetch_buffer.md
# zilla_fetch_buffer

Instruction fetch buffer between the PC-update stage and decode in the Zilla core. It issues one instruction-memory read per PC offered by the PC-update stage and captures the fixed-latency response. Fetched words are queued with their PCs in a small FIFO and handed to decode over a valid/ready handshake. The block back-pressures the PC-update stage through its stall input and discards all queued and in-flight fetches on a redirect (branch, trap entry/exit, debug entry).

## Interface
Parameters:
- PC_WIDTH, 20, width of PC / instruction address
- INSTRUCTION_WIDTH, 32, instruction word width
- DEPTH, 4, FIFO entries; power of two, ≥2

Ports:
- z_clk  in  1  core clock; all state on rising edge
- z_rst  in  1  reset, asynchronous, active-low
- instr_read_addr_i  in  PC_WIDTH  current PC from PC-update stage
- instr_read_enable_i  in  1  PC-update stage requests a fetch of instr_read_addr_i
- flush_i  in  1  redirect; discard FIFO contents and in-flight fetch
- imem_addr_o  out  PC_WIDTH  instruction memory address (= instr_read_addr_i, combinational)
- imem_req_o  out  1  instruction memory read strobe
- imem_rdata_i  in  INSTRUCTION_WIDTH  read data, valid exactly one cycle after imem_req_o
- instr_valid_o  out  1  FIFO head valid to decode
- instr_o  out  INSTRUCTION_WIDTH  head instruction
- instr_pc_o  out  PC_WIDTH  PC of head instruction
- instr_ready_i  in  1  decode accepts head this cycle
- stall_valid_o  out  1  to PC-update stall input; hold PC, no new fetch

## Operation
- State: FIFO storage (instr + PC per entry), rd_ptr/wr_ptr (log2 DEPTH bits, wrap mod DEPTH), count (log2 DEPTH + 1 bits), inflight_r, inflight_pc_r.
- stall_valid_o = (count + inflight_r) ≥ DEPTH; driven from registers only; no combinational path from instr_ready_i, instr_read_enable_i or flush_i.
- imem_req_o = instr_read_enable_i & ~stall_valid_o & ~flush_i.
- Request accepted: inflight_r ← 1, inflight_pc_r ← instr_read_addr_i; otherwise inflight_r ← 0.
- Push: when inflight_r = 1 and flush_i = 0, write {imem_rdata_i, inflight_pc_r} at wr_ptr, wr_ptr++.
- Pop: instr_valid_o & instr_ready_i & ~flush_i → rd_ptr++.
- instr_valid_o = (count != 0). instr_o/instr_pc_o = entry at rd_ptr; don't-care when invalid.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Flush: rd_ptr, wr_ptr, count ← 0; inflight_r ← 0 (returning data dropped); same-cycle request and pop suppressed. A request in the cycle after the flush proceeds normally.
- No overflow by construction: a request is only issued when count + inflight_r < DEPTH. A push into a full FIFO is an assertion failure.
- No underflow: pop is gated by instr_valid_o.

## Timing
- Reset: imem_req_o 0, instr_valid_o 0, stall_valid_o 0, instr_o 0, instr_pc_o 0 (storage cleared), pointers/count/inflight 0.
- Request at cycle N → data sampled at N+1 → instr_valid_o at N+2. Fetch-to-decode latency is 2 cycles.
- Sustained throughput is 1 instruction/cycle when decode is always ready.
- stall_valid_o rises the cycle after count + inflight_r reaches DEPTH. It falls the cycle after a pop or a flush reduces that sum.
- Reset asserted mid-fetch: all state cleared asynchronously; the returning response is ignored.

## Structure
- Shared package zilla_pkg: PC_WIDTH, INSTRUCTION_WIDTH, boot address 20'h8100, FETCH_BUF_DEPTH.
- One sub-module, zilla_fetch_fifo: generic sync FIFO (push/pop/flush, count, full/empty) of width INSTRUCTION_WIDTH+PC_WIDTH. Request/in-flight control and stall generation live in the top.

## Test plan
- Streaming: enable held high from PC 0x8100, ready=1 → imem_req_o every cycle; instr_pc_o 0x8100, 0x8104, 0x8108… starting cycle 2; stall_valid_o never asserted.
- Back-pressure: ready=0, DEPTH=4 → exactly 4 requests; stall_valid_o high from the cycle after the 4th request; count=4. Pulse ready for 1 cycle → one pop, stall drops next cycle, one further request.
- Flush with in-flight fetch: request PC 0x8200, flush_i at N+1 with 2 entries queued → instr_valid_o 0 at N+2; 0x8200 data never appears; next request (PC 0x9000) delivered at its N'+2.
- Simultaneous push/pop at count=2 → count stays 2, order preserved across pointer wrap (PCs 0x8100…0x811C through DEPTH=4).
- Async reset asserted mid-stream with 3 entries → all outputs 0 immediately; after release, first fetch from 0x8100 valid 2 cycles after its request.
- Flush in the same cycle as instr_ready_i and instr_read_enable_i → no pop counted, imem_req_o 0, FIFO empty next cycle.
